// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared single-port memory.
// Data side wins ties unless the fetch side has waited STARVE_LIMIT grants.
module mem_arbiter #(
    parameter int WORD_BITWIDTH = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_req,
    input  logic [WORD_BITWIDTH-1:0] i_addr,
    output logic [WORD_BITWIDTH-1:0] i_rdata,
    output logic                     i_ack,
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [WORD_BITWIDTH-1:0] d_addr,
    input  logic [WORD_BITWIDTH-1:0] d_wdata,
    output logic [WORD_BITWIDTH-1:0] d_rdata,
    output logic                     d_ack,
    output logic                     m_req,
    output logic                     m_we,
    output logic [WORD_BITWIDTH-1:0] m_addr,
    output logic [WORD_BITWIDTH-1:0] m_wdata,
    input  logic [WORD_BITWIDTH-1:0] m_rdata,
    input  logic                     m_ack,
    output logic                     busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT_I = 2'd1;
    localparam logic [1:0] GRANT_D = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic       pick_i;
    logic       pick_d;

    always_comb begin
        pick_i = i_req && (!d_req || starve_cnt == LIMIT);
        pick_d = d_req && !pick_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            busy       <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        pick_i: begin
                            state      <= GRANT_I;
                            m_req      <= 1'b1;
                            m_we       <= 1'b0;
                            m_addr     <= i_addr;
                            busy       <= 1'b1;
                            starve_cnt <= '0;
                        end
                        pick_d: begin
                            state   <= GRANT_D;
                            m_req   <= 1'b1;
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            busy    <= 1'b1;
                            // Only count grants that actually made a fetch wait
                            if (i_req && starve_cnt != LIMIT)
                                starve_cnt <= starve_cnt + 4'd1;
                        end
                        default: ;
                    endcase
                end
                GRANT_I: begin
                    if (m_ack) begin
                        state   <= DONE;
                        m_req   <= 1'b0;
                        m_we    <= 1'b0;
                        i_ack   <= 1'b1;
                        i_rdata <= m_rdata;
                    end
                end
                GRANT_D: begin
                    if (m_ack) begin
                        state <= DONE;
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        d_ack <= 1'b1;
                        if (!m_we)
                            d_rdata <= m_rdata;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store/load, contention,
// starvation, reset mid-transaction, late drop and stray ack.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;
    int i_acks   = 0;
    int d_acks   = 0;
    logic prev_i_ack = 1'b0;
    logic prev_d_ack = 1'b0;

    mem_arbiter #(.WORD_BITWIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("ack_excl", 32'(i_ack & d_ack), 32'd0);
            check("i_ack_len", 32'(i_ack & prev_i_ack), 32'd0);
            check("d_ack_len", 32'(d_ack & prev_d_ack), 32'd0);
        end
        if (i_ack) i_acks++;
        if (d_ack) d_acks++;
        prev_i_ack = i_ack;
        prev_d_ack = d_ack;
    end

    task automatic wait_mreq();
        int n = 0;
        tick();
        while (!m_req && n < 20) begin
            tick();
            n++;
        end
        check("mreq_timeout", 32'(m_req), 32'd1);
    endtask

    task automatic ack_after(int lat, logic [31:0] data);
        repeat (lat - 1) tick();
        m_ack   = 1'b1;
        m_rdata = data;
        tick();
        m_ack   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        rst = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; m_rdata = 0; m_ack = 0;
        repeat (3) tick();
        check("rst_mreq", 32'(m_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_acks", 32'({i_ack, d_ack, m_we}), 32'd0);
        check("rst_maddr", m_addr, 32'd0);
        check("rst_mwdata", m_wdata, 32'd0);
        check("rst_rdata", i_rdata | d_rdata, 32'd0);
        check("rst_starve", 32'(dut.starve_cnt), 32'd0);
        rst = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // single fetch
        i_req = 1; i_addr = 32'h100;
        wait_mreq();
        check("f_addr", m_addr, 32'h100);
        check("f_we", 32'(m_we), 32'd0);
        check("f_busy", 32'(busy), 32'd1);
        ack_after(2, 32'h00500093);
        check("f_ack", 32'(i_ack), 32'd1);
        check("f_rdata", i_rdata, 32'h00500093);
        check("f_mreq_off", 32'(m_req), 32'd0);
        i_req = 0;
        tick();
        check("f_ack_off", 32'(i_ack), 32'd0);
        check("f_idle", 32'(busy), 32'd0);

        // store then load
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        wait_mreq();
        check("st_we", 32'(m_we), 32'd1);
        check("st_addr", m_addr, 32'h40);
        check("st_wdata", m_wdata, 32'hDEADBEEF);
        d_addr = 32'h999; d_wdata = 32'h0;
        tick();
        check("st_hold_addr", m_addr, 32'h40);
        check("st_hold_wdata", m_wdata, 32'hDEADBEEF);
        ack_after(1, 32'h12345678);
        check("st_ack", 32'(d_ack), 32'd1);
        check("st_rdata", d_rdata, 32'd0);
        check("st_we_off", 32'(m_we), 32'd0);
        d_req = 0;
        tick();
        d_req = 1; d_we = 0; d_addr = 32'h40;
        wait_mreq();
        check("ld_we", 32'(m_we), 32'd0);
        check("ld_addr", m_addr, 32'h40);
        ack_after(3, 32'hDEADBEEF);
        check("ld_ack", 32'(d_ack), 32'd1);
        check("ld_rdata", d_rdata, 32'hDEADBEEF);
        d_req = 0;
        repeat (2) tick();

        // contention
        i_req = 1; i_addr = 32'h200;
        d_req = 1; d_we = 0; d_addr = 32'h80;
        wait_mreq();
        check("ct_first", m_addr, 32'h80);
        check("ct_starve1", 32'(dut.starve_cnt), 32'd1);
        ack_after(1, 32'hAA);
        check("ct_d_ack", 32'(d_ack), 32'd1);
        check("ct_d_rdata", d_rdata, 32'hAA);
        d_req = 0;
        tick();
        check("ct_gap_busy", 32'(busy), 32'd0);
        check("ct_gap_mreq", 32'(m_req), 32'd0);
        tick();
        check("ct_i_grant", 32'(m_req), 32'd1);
        check("ct_i_addr", m_addr, 32'h200);
        check("ct_starve0", 32'(dut.starve_cnt), 32'd0);
        ack_after(2, 32'hBB);
        check("ct_i_ack", 32'(i_ack), 32'd1);
        check("ct_i_rdata", i_rdata, 32'hBB);
        i_req = 0;
        repeat (2) tick();

        // starvation
        i_req = 1; i_addr = 32'h300;
        d_req = 1; d_we = 1; d_addr = 32'h90; d_wdata = 32'h11;
        for (int k = 0; k < 5; k++) begin
            wait_mreq();
            check($sformatf("sv_we%0d", k), 32'(m_we), (k < 4) ? 32'd1 : 32'd0);
            check($sformatf("sv_addr%0d", k), m_addr,
                  (k < 4) ? 32'h90 : 32'h300);
            check($sformatf("sv_cnt%0d", k), 32'(dut.starve_cnt),
                  (k < 4) ? 32'(k + 1) : 32'd0);
            ack_after(1, 32'h0);
            if (k == 4) begin
                i_req = 0;
                d_req = 0;
            end
        end
        repeat (2) tick();

        // reset mid-transaction
        saved = d_acks;
        d_req = 1; d_we = 0; d_addr = 32'h44;
        wait_mreq();
        check("rm_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rm_mreq", 32'(m_req), 32'd0);
        check("rm_busy0", 32'(busy), 32'd0);
        d_req = 0;
        tick();
        rst = 1'b1;
        m_ack = 1; m_rdata = 32'hCC;
        tick();
        m_ack = 0;
        tick();
        check("rm_no_ack", 32'(d_acks), 32'(saved));
        check("rm_idle", 32'({busy, m_req}), 32'd0);
        check("rm_rdata", d_rdata, 32'd0);

        // late drop
        saved = d_acks;
        d_req = 1; d_we = 0; d_addr = 32'h48;
        wait_mreq();
        tick();
        d_req = 0;
        ack_after(1, 32'h55);
        check("ld_late_ack", 32'(d_ack), 32'd1);
        check("ld_late_rdata", d_rdata, 32'h55);
        repeat (3) tick();
        check("ld_once", 32'(d_acks), 32'(saved + 1));

        // stray ack in idle
        saved = i_acks + d_acks;
        m_ack = 1; m_rdata = 32'h77;
        tick();
        m_ack = 0;
        tick();
        check("sa_busy", 32'({busy, m_req}), 32'd0);
        check("sa_noack", 32'(i_acks + d_acks), 32'(saved));
        check("sa_rdata", d_rdata, 32'h55);
        check("sa_state", 32'(dut.state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_BITWIDTH, default 32: width of every address and data bus.
REQ-002 Parameter STARVE_LIMIT, default 4: maximum consecutive data grants while an instruction request waits; legal range 1..15.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset; rst=0 resets immediately, independent of clk.
REQ-005 i_req  in  1  instruction fetch request; held high until i_ack.
REQ-006 i_addr  in  WORD_BITWIDTH  instruction fetch address.
REQ-007 i_rdata  out  WORD_BITWIDTH  fetched instruction; valid while i_ack=1 and held until the next fetch completes.
REQ-008 i_ack  out  1  one-cycle pulse marking fetch completion.
REQ-009 d_req  in  1  data access request; held high until d_ack.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_addr, d_wdata  in  WORD_BITWIDTH each  data address and store data.
REQ-012 d_rdata  out  WORD_BITWIDTH  load data; valid while d_ack=1 and held until the next load completes.
REQ-013 d_ack  out  1  one-cycle pulse marking data access completion.
REQ-014 m_req  out  1  request to the shared single-port memory.
REQ-015 m_we  out  1  memory write enable.
REQ-016 m_addr, m_wdata  out  WORD_BITWIDTH each  memory address and write data.
REQ-017 m_rdata  in  WORD_BITWIDTH  memory read data; valid in the m_ack cycle.
REQ-018 m_ack  in  1  memory completion; variable latency of at least 1 cycle after m_req rises.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 The FSM shall have four states: IDLE, GRANT_I, GRANT_D and DONE. All outputs shall be registered.
REQ-021 In IDLE, when only i_req=1, the next state shall be GRANT_I. When only d_req=1, the next state shall be GRANT_D. When neither is high, the FSM shall remain in IDLE.
REQ-022 In IDLE with i_req=d_req=1, the data requester shall win. The exception is starve_cnt==STARVE_LIMIT, in which case the instruction requester shall win.
REQ-023 starve_cnt shall increment, saturating at STARVE_LIMIT, on each data grant made while i_req=1. It shall clear to 0 on every instruction grant.
REQ-024 On the grant edge, the block shall latch address, we and wdata into m_addr/m_we/m_wdata and set m_req=1. Instruction grants shall always drive m_we=0.
REQ-025 m_req, m_addr, m_we and m_wdata shall hold stable throughout GRANT_I/GRANT_D. Requester input changes after the grant shall be ignored.
REQ-026 On the edge where m_ack=1 in a GRANT state, the block shall:
- clear m_req and m_we;
- enter DONE;
- drive the matching ack high for exactly one cycle;
- latch m_rdata into i_rdata (GRANT_I) or into d_rdata (GRANT_D loads only; stores leave d_rdata unchanged).
REQ-027 DONE shall last exactly one cycle and then return to IDLE. Requests shall not be sampled in DONE, so a requester that drops req after seeing ack is never re-granted.
REQ-028 m_ack while in IDLE or DONE shall be ignored.
REQ-029 Minimum transaction length shall be 4 cycles: grant edge, m_ack edge, DONE cycle, IDLE cycle. Back-to-back transactions shall therefore be separated by one IDLE cycle.
REQ-030 A requester that deasserts req while granted shall still receive its ack; the memory transaction shall not be aborted.
REQ-031 i_ack and d_ack shall never be high in the same cycle, and m_req shall never serve two requesters at once.

Reset
REQ-032 While rst=0, the block shall hold:
- state=IDLE;
- m_req=0, m_we=0, i_ack=0, d_ack=0, busy=0;
- m_addr, m_wdata, i_rdata and d_rdata = 0;
- starve_cnt=0.
REQ-033 rst asserted mid-transaction shall drop m_req and busy immediately (asynchronously), and no ack shall be issued for the aborted transaction.
REQ-034 After rst returns to 1, the first grant shall occur no earlier than the first rising edge.

Verification
REQ-035 Single fetch: i_req=1, i_addr=0x100, m_ack returned 2 cycles after m_req with m_rdata=0x00500093 -> m_addr=0x100, m_we=0, i_ack pulse of 1 cycle, i_rdata=0x00500093.
REQ-036 Store then load: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> m_we=1, m_wdata=0xDEADBEEF, d_ack pulse, d_rdata unchanged. Then a load of 0x40 with m_rdata=0xDEADBEEF -> d_rdata=0xDEADBEEF.
REQ-037 Contention: i_req and d_req raised on the same cycle -> data granted first and the fetch granted immediately after; verify the single IDLE gap and no overlapping acks.
REQ-038 Starvation: i_req held high while d_req stays high through repeated transactions, STARVE_LIMIT=4 -> exactly 4 data grants, then an instruction grant, then starve_cnt=0.
REQ-039 Reset mid-op: rst=0 while in GRANT_D awaiting m_ack -> m_req=0, busy=0 within the same cycle, no d_ack. A later m_ack is ignored.
REQ-040 Late drop and stray ack: d_req dropped one cycle after grant -> d_ack still pulses once. m_ack pulsed in IDLE -> no ack and no state change.
